// File: rtl/card_game_pkg.sv
// Shared definitions for the memory card game.
// Contents: board geometry localparams and the turn controller state enum.
package card_game_pkg;
  localparam int NUM_CARDS = 36;
  localparam int NUM_PAIRS = NUM_CARDS / 2;
  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 5;

  typedef enum logic [2:0] {
    SEL1, RD1, SEL2, RD2, CMP, REVEAL, OVER
  } ctl_state_t;
endpackage

// File: rtl/reveal_timer.sv
// Mismatch hold down-counter.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   load         : load REVEAL_CYCLES-1
//   dec          : decrement (holds at zero)
//   zero         : count is zero
module reveal_timer #(
  parameter int REVEAL_CYCLES = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int W = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(REVEAL_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset)                     count <= '0;
    else if (load)                 count <= LOAD_VAL;
    else if (dec && count != '0)   count <= count - 1'b1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/card_turn_controller.sv
// Turn sequencer for the memory card game: accepts two selections, reads
// both card values from the card memory, compares them, then either marks
// the pair as matched or holds both cards face-up for REVEAL_CYCLES clocks.
// Ports:
//   clock, reset            : system clock, synchronous active-high reset
//   btn_a, cursor           : select pulse and card under the cursor
//   mem_addr, mem_data      : card memory read port (address registered)
//   card1_addr, card2_addr  : selected cards
//   show1, show2            : selected cards face-up
//   matched, pairs_found    : permanently revealed cards, pair count
//   busy, game_over         : presses ignored / all pairs found
// Optional feature: define TURN_COUNT_EN to add output turns[9:0], a
// saturating (999) count of compare cycles.
module card_turn_controller #(
  parameter int NUM_CARDS     = card_game_pkg::NUM_CARDS,
  parameter int ADDR_W        = card_game_pkg::ADDR_W,
  parameter int DATA_W        = card_game_pkg::DATA_W,
  parameter int MEM_LAT       = 1,
  parameter int REVEAL_CYCLES = 50_000_000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 btn_a,
  input  logic [ADDR_W-1:0]    cursor,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_data,
  output logic [ADDR_W-1:0]    card1_addr,
  output logic [ADDR_W-1:0]    card2_addr,
  output logic                 show1,
  output logic                 show2,
  output logic [NUM_CARDS-1:0] matched,
  output logic [4:0]           pairs_found,
  output logic                 busy,
  output logic                 game_over
`ifdef TURN_COUNT_EN
  ,
  output logic [9:0]           turns
`endif
);
  import card_game_pkg::*;

  localparam int PAIRS = NUM_CARDS / 2;
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  ctl_state_t        state;
  logic [DATA_W-1:0] val1, val2;
  logic [LAT_W-1:0]  lat_cnt;
  logic              lat_done, in_range, taken, accept, timer_zero;
  logic [4:0]        pairs_next;

  // Out-of-range cursors are treated as already taken so the bitmap is
  // never indexed past its end.
  assign in_range   = (int'(cursor) < NUM_CARDS);
  assign taken      = in_range ? matched[cursor] : 1'b1;
  assign accept     = btn_a && !taken &&
                      ((state == SEL1) ||
                       (state == SEL2 && cursor != card1_addr));
  assign lat_done   = (lat_cnt == LAT_W'(MEM_LAT - 1));
  assign pairs_next = pairs_found + 5'd1;

  assign busy      = (state == RD1) || (state == RD2) || (state == CMP) ||
                     (state == REVEAL) || (state == OVER);
  assign game_over = (state == OVER);

  reveal_timer #(.REVEAL_CYCLES(REVEAL_CYCLES)) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (state == CMP && val1 != val2),
    .dec   (state == REVEAL),
    .zero  (timer_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= SEL1;
      mem_addr    <= '0;
      card1_addr  <= '0;
      card2_addr  <= '0;
      show1       <= 1'b0;
      show2       <= 1'b0;
      matched     <= '0;
      pairs_found <= '0;
      val1        <= '0;
      val2        <= '0;
      lat_cnt     <= '0;
    end else begin
      case (state)
        SEL1: if (accept) begin
          card1_addr <= cursor;
          mem_addr   <= cursor;
          show1      <= 1'b1;
          lat_cnt    <= '0;
          state      <= RD1;
        end
        // mem_data is only trusted on the last cycle of the read wait.
        RD1: if (lat_done) begin
          val1  <= mem_data;
          state <= SEL2;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
        SEL2: if (accept) begin
          card2_addr <= cursor;
          mem_addr   <= cursor;
          show2      <= 1'b1;
          lat_cnt    <= '0;
          state      <= RD2;
        end
        RD2: if (lat_done) begin
          val2  <= mem_data;
          state <= CMP;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
        CMP: if (val1 == val2) begin
          matched[card1_addr] <= 1'b1;
          matched[card2_addr] <= 1'b1;
          pairs_found         <= pairs_next;
          show1               <= 1'b0;
          show2               <= 1'b0;
          state               <= (pairs_next == 5'(PAIRS)) ? OVER : SEL1;
        end else begin
          state <= REVEAL;
        end
        // Timer was loaded with REVEAL_CYCLES-1 in CMP, so the cards are
        // face-up for exactly REVEAL_CYCLES cycles after CMP.
        REVEAL: if (timer_zero) begin
          show1 <= 1'b0;
          show2 <= 1'b0;
          state <= SEL1;
        end
        OVER:    ;
        default: state <= SEL1;
      endcase
    end
  end

`ifdef TURN_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset)                             turns <= '0;
    else if (state == CMP && turns != 10'd999) turns <= turns + 10'd1;
  end
`endif
endmodule

// File: tb/tb_card_turn_controller.sv
// Self-checking bench for card_turn_controller (REVEAL_CYCLES=4, MEM_LAT=1).
// A transaction-level model tracks which cards are matched, which card is
// waiting for its partner and the pair count, and predicts the outcome of
// every press.
module tb_card_turn_controller;
  localparam int NUM = 36;
  localparam int HOLD = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        btn_a = 1'b0;
  logic [5:0]  cursor = '0;
  logic [5:0]  mem_addr, card1_addr, card2_addr;
  logic [4:0]  mem_data;
  logic        show1, show2, busy, game_over;
  logic [35:0] matched;
  logic [4:0]  pairs_found;
`ifdef TURN_COUNT_EN
  logic [9:0]  turns;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // model
  logic [63:0] m_matched;
  int          m_pairs, m_c1, m_addr, m_turns;
  bit          m_sel2, m_over;
  logic [4:0]  mem [64];

  always #5 clock = ~clock;

  // Latency 1: data for the new address is valid by the end of the
  // cycle following the address change.
  assign mem_data = mem[mem_addr];

  card_turn_controller #(.MEM_LAT(1), .REVEAL_CYCLES(HOLD)) dut (
    .clock(clock), .reset(reset), .btn_a(btn_a), .cursor(cursor),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .card1_addr(card1_addr), .card2_addr(card2_addr),
    .show1(show1), .show2(show2), .matched(matched),
    .pairs_found(pairs_found), .busy(busy), .game_over(game_over)
`ifdef TURN_COUNT_EN
    , .turns(turns)
`endif
  );

  function automatic logic [4:0] card_val(input int i);
    int p;
    p = i / 2;
    if (p == 0) return 5'd7;
    if (p == 1) return 5'd3;
    return 5'(p + 10);
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic model_reset();
    m_matched = '0; m_pairs = 0; m_c1 = 0; m_addr = 0; m_turns = 0;
    m_sel2 = 0; m_over = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; btn_a = 1'b0; tick(); reset = 1'b0; model_reset();
  endtask

  // One press, fully checked against the model, ending in an idle state.
  task automatic play(input int cur);
    bit acc;
    int hold;
    acc = !m_over && cur < NUM && !m_matched[cur] && !(m_sel2 && cur == m_c1);
    cursor = 6'(cur); btn_a = 1'b1; tick(); btn_a = 1'b0;
    cursor = 6'($urandom_range(0, 63));
    if (!acc) begin
      n_checks++;
      if ({mem_addr, show1, show2, busy, pairs_found} !==
          {6'(m_addr), m_sel2, 1'b0, m_over, 5'(m_pairs)})
        begin n_fail++; $display("FAIL reject cur=%0d: got addr=%0d s1=%b s2=%b busy=%b pairs=%0d, want addr=%0d s1=%b s2=0 busy=%b pairs=%0d",
          cur, mem_addr, show1, show2, busy, pairs_found, m_addr, m_sel2, m_over, m_pairs); end
    end else if (!m_sel2) begin
      n_checks++;
      if ({card1_addr, mem_addr, show1, show2, busy} !== {6'(cur), 6'(cur), 3'b101})
        begin n_fail++; $display("FAIL first_sel cur=%0d: got c1=%0d addr=%0d s1=%b s2=%b busy=%b",
          cur, card1_addr, mem_addr, show1, show2, busy); end
      tick();
      n_checks++;
      if ({busy, show1} !== 2'b01)
        begin n_fail++; $display("FAIL sel2_idle: got busy=%b s1=%b want busy=0 s1=1", busy, show1); end
      m_sel2 = 1; m_c1 = cur; m_addr = cur;
    end else begin
      n_checks++;
      if ({card2_addr, mem_addr, show1, show2, busy} !== {6'(cur), 6'(cur), 3'b111})
        begin n_fail++; $display("FAIL second_sel cur=%0d: got c2=%0d addr=%0d s1=%b s2=%b busy=%b",
          cur, card2_addr, mem_addr, show1, show2, busy); end
      m_addr = cur; m_sel2 = 0;
      if (m_turns < 999) m_turns++;
      tick();          // compare cycle
      n_checks++;
      if (busy !== 1'b1)
        begin n_fail++; $display("FAIL cmp_busy: got %b want 1", busy); end
      tick();          // cycle after compare
      if (card_val(m_c1) == card_val(cur)) begin
        m_matched[m_c1] = 1'b1; m_matched[cur] = 1'b1; m_pairs++;
        m_over = (m_pairs == NUM / 2);
        n_checks++;
        if ({matched, pairs_found, show1, show2, busy, game_over} !==
            {m_matched[35:0], 5'(m_pairs), 2'b00, m_over, m_over})
          begin n_fail++; $display("FAIL match %0d/%0d: got matched=%h pairs=%0d s=%b%b busy=%b go=%b want matched=%h pairs=%0d over=%b",
            m_c1, cur, matched, pairs_found, show1, show2, busy, game_over, m_matched[35:0], m_pairs, m_over); end
      end else begin
        hold = 0;
        while (show1 && show2 && hold < 20) begin hold++; tick(); end
        n_checks++;
        if (hold != HOLD)
          begin n_fail++; $display("FAIL reveal_len %0d/%0d: got %0d want %0d", m_c1, cur, hold, HOLD); end
        n_checks++;
        if ({matched, pairs_found, busy} !== {m_matched[35:0], 5'(m_pairs), 1'b0})
          begin n_fail++; $display("FAIL mismatch_state: got matched=%h pairs=%0d busy=%b want matched=%h pairs=%0d busy=0",
            matched, pairs_found, busy, m_matched[35:0], m_pairs); end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_a = 1'b1; cursor = 6'd5; tick();
    reset = 1'b0; btn_a = 1'b0; model_reset();
    n_checks++;
    if ({mem_addr, card1_addr, card2_addr, show1, show2, matched, pairs_found, busy, game_over} !== '0)
      begin n_fail++; $display("FAIL reset: got addr=%0d c1=%0d c2=%0d s=%b%b matched=%h pairs=%0d busy=%b go=%b want all 0",
        mem_addr, card1_addr, card2_addr, show1, show2, matched, pairs_found, busy, game_over); end
  endtask

  task automatic test_match();
    do_reset(); play(0); play(1);
  endtask

  task automatic test_mismatch();
    do_reset(); play(0); play(2);
  endtask

  task automatic test_rejects();
    do_reset();
    play(0); play(0); play(40); play(1);   // same card, out of range, match
    play(1); play(0); play(63);            // matched cards, out of range
    play(2); play(1); play(2); play(4);    // matched as partner, same, mismatch
  endtask

  task automatic test_reject_in_reveal();
    int hold;
    do_reset(); play(0);
    cursor = 6'd2; btn_a = 1'b1; tick(); btn_a = 1'b0;
    tick(); tick();                        // first reveal cycle
    cursor = 6'd4; btn_a = 1'b1; tick(); btn_a = 1'b0;
    n_checks++;
    if ({mem_addr, card1_addr, card2_addr, show1, show2, busy} !== {6'd2, 6'd0, 6'd2, 3'b111})
      begin n_fail++; $display("FAIL reveal_press: got addr=%0d c1=%0d c2=%0d s=%b%b busy=%b want addr=2 c1=0 c2=2 s=11 busy=1",
        mem_addr, card1_addr, card2_addr, show1, show2, busy); end
    hold = 0;
    while (show1 && show2 && hold < 20) begin hold++; tick(); end
    n_checks++;
    if (hold != HOLD - 1)
      begin n_fail++; $display("FAIL reveal_rest: got %0d want %0d", hold, HOLD - 1); end
    m_sel2 = 0; m_addr = 2; m_turns++;
    play(4); play(5);
  endtask

  task automatic test_reset_in_reveal();
    do_reset(); play(0); play(1); play(2);
    cursor = 6'd4; btn_a = 1'b1; tick(); btn_a = 1'b0;
    tick(); tick(); tick();                // second reveal cycle
    reset = 1'b1; tick(); reset = 1'b0; model_reset();
    n_checks++;
    if ({mem_addr, card1_addr, card2_addr, show1, show2, matched, pairs_found, busy, game_over} !== '0)
      begin n_fail++; $display("FAIL reset_reveal: got addr=%0d c1=%0d c2=%0d s=%b%b matched=%h pairs=%0d busy=%b want all 0",
        mem_addr, card1_addr, card2_addr, show1, show2, matched, pairs_found, busy); end
    play(0); play(1);                      // card 0 selectable again
  endtask

  task automatic test_game_over();
    int order [18];
    int j, t;
    do_reset();
    for (int i = 0; i < 18; i++) order[i] = i;
    for (int i = 17; i > 0; i--) begin
      j = $urandom_range(0, i); t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 18; i++) begin
      if ($urandom_range(0, 1) == 1) begin play(2*order[i] + 1); play(2*order[i]); end
      else begin play(2*order[i]); play(2*order[i] + 1); end
    end
    n_checks++;
    if ({game_over, busy, pairs_found, matched} !== {2'b11, 5'd18, {36{1'b1}}})
      begin n_fail++; $display("FAIL game_over: got go=%b busy=%b pairs=%0d matched=%h", game_over, busy, pairs_found, matched); end
    play(3); play(45);
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if ({game_over, pairs_found} !== {1'b1, 5'd18})
      begin n_fail++; $display("FAIL over_sticky: got go=%b pairs=%0d want go=1 pairs=18", game_over, pairs_found); end
  endtask

  task automatic test_random();
    int cur;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      if (m_over) do_reset();
      if (m_sel2 && $urandom_range(0, 2) == 0) cur = m_c1 ^ 1;
      else cur = $urandom_range(0, 39);
      play(cur);
    end
  endtask

`ifdef TURN_COUNT_EN
  task automatic test_turns();
    do_reset();
    play(0); play(2); play(0); play(4); play(0); play(6); play(0); play(1);
    n_checks++;
    if (turns !== 10'd4)
      begin n_fail++; $display("FAIL turns: got %0d want 4", turns); end
    test_random();
    n_checks++;
    if (turns !== 10'(m_turns))
      begin n_fail++; $display("FAIL turns_random: got %0d want %0d", turns, m_turns); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = (i < NUM) ? card_val(i) : 5'd0;
    model_reset();
    tick();
    test_reset();
    test_match();
    test_mismatch();
    test_rejects();
    test_reject_in_reveal();
    test_reset_in_reveal();
    test_game_over();
    test_random();
`ifdef TURN_COUNT_EN
    test_turns();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: run did not complete within time bound");
    $fatal(1, "watchdog");
  end
endmodule
